// File: rtl/hazard_tracker_pkg.sv
// rtl/hazard_tracker_pkg.sv - shared pipeline types for the hazard tracker
package hazard_tracker_pkg;

    // Widest register index a stage record can carry; NREG up to 256.
    localparam int REG_W_MAX = 8;

    // Operand source select presented to the Execute-stage operand muxes.
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwdSel_t;

    // What the tracker remembers about the instruction occupying a stage.
    typedef struct packed {
        logic                 valid;
        logic [REG_W_MAX-1:0] rd;
        logic                 regWrite;
        logic                 memToReg;
        logic                 pcWrite;
    } stageRec_t;

    // An empty slot: loaded on flushes, memory-wait bubbles and reset.
    localparam stageRec_t BUBBLE = '0;

endpackage

// File: rtl/hazard_tracker_match.sv
// rtl/hazard_tracker_match.sv - one source register versus one stage record
module hazard_match
    import hazard_tracker_pkg::*;
#(
    parameter int RW   = 4,
    parameter int NREG = 16
)
(
    input  logic [RW-1:0] src,
    input  logic          srcUsed,
    input  stageRec_t     stage,
    output logic          match
);

    logic [REG_W_MAX-1:0] srcWide;
    logic                 unusedFields;

    assign srcWide      = REG_W_MAX'(src);
    // Load and PC-write flags matter to the caller, not to the comparison.
    assign unusedFields = &{1'b0, stage.memToReg, stage.pcWrite};

    // The PC is never forwarded or interlocked through the register path.
    assign match = stage.valid & stage.regWrite & srcUsed
                 & (stage.rd == srcWide)
                 & (src != RW'(NREG - 1));

endmodule

// File: rtl/hazard_tracker.sv
// rtl/hazard_tracker.sv - pipeline hazard detection, forwarding and perf counters
module hazard_tracker
    import hazard_tracker_pkg::*;
#(
    parameter int NSRC  = 2,
    parameter int NREG  = 16,
    parameter int CNT_W = 16
)
(
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ValidD,
    input  logic [NSRC*$clog2(NREG)-1:0]    SrcRegD,
    input  logic [NSRC-1:0]                 SrcUsedD,
    input  logic [$clog2(NREG)-1:0]         RdD,
    input  logic                            RegWriteD,
    input  logic                            MemtoRegD,
    input  logic                            PCWriteD,
    input  logic                            BranchTakenE,
    input  logic                            MemStallM,
    input  logic                            CntClr,
    output logic                            StallF,
    output logic                            StallD,
    output logic                            StallE,
    output logic                            StallM,
    output logic                            FlushD,
    output logic                            FlushE,
    output logic                            BubbleW,
    output logic [NSRC*2-1:0]               ForwardE,
    output logic [CNT_W-1:0]                CntStall,
    output logic [CNT_W-1:0]                CntFlush
);

    localparam int RW = $clog2(NREG);

    stageRec_t          recD;
    stageRec_t          recE;
    stageRec_t          recM;
    stageRec_t          recW;
    logic [NSRC*RW-1:0] srcE;
    logic [NSRC-1:0]    srcUsedE;

    logic [NSRC-1:0]    matchDE;
    logic [NSRC-1:0]    matchEM;
    logic [NSRC-1:0]    matchEW;

    logic               decodeValid;
    logic               ldStall;
    logic               pcWrPending;

    // Pack the Decode control bits into the same record shape the stages use.
    always_comb begin
        recD          = BUBBLE;
        recD.valid    = ValidD;
        recD.rd       = REG_W_MAX'(RdD);
        recD.regWrite = RegWriteD;
        recD.memToReg = MemtoRegD;
        recD.pcWrite  = PCWriteD;
    end

    // Decode sources against E (load-use); E sources against M and W (forwarding).
    genvar g;
    generate
        for (g = 0; g < NSRC; g++) begin : gSrc
            hazard_match #(.RW(RW), .NREG(NREG)) uMatchDE (
                .src     (SrcRegD[g*RW +: RW]),
                .srcUsed (SrcUsedD[g]),
                .stage   (recE),
                .match   (matchDE[g])
            );
            hazard_match #(.RW(RW), .NREG(NREG)) uMatchEM (
                .src     (srcE[g*RW +: RW]),
                .srcUsed (srcUsedE[g]),
                .stage   (recM),
                .match   (matchEM[g])
            );
            hazard_match #(.RW(RW), .NREG(NREG)) uMatchEW (
                .src     (srcE[g*RW +: RW]),
                .srcUsed (srcUsedE[g]),
                .stage   (recW),
                .match   (matchEW[g])
            );
        end
    endgenerate

    // Per-port operand select; the younger result in M wins over W.
    always_comb begin
        ForwardE = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (matchEM[i]) begin
                ForwardE[i*2 +: 2] = FWD_M;
            end else if (matchEW[i]) begin
                ForwardE[i*2 +: 2] = FWD_W;
            end
        end
    end

    // Decode is masked during reset so only the live E/M inputs can assert outputs.
    assign decodeValid = ValidD & reset;
    assign ldStall     = decodeValid & recE.valid & recE.memToReg & (|matchDE);
    assign pcWrPending = (decodeValid & PCWriteD)
                       | (recE.valid & recE.pcWrite)
                       | (recM.valid & recM.pcWrite);

    assign StallF  = ldStall | pcWrPending | MemStallM;
    assign StallD  = ldStall | MemStallM;
    assign StallE  = MemStallM;
    assign StallM  = MemStallM;
    assign BubbleW = MemStallM;
    // A branch held through a memory wait flushes once the wait lifts.
    assign FlushD  = ~MemStallM & (pcWrPending | (recW.valid & recW.pcWrite) | BranchTakenE);
    assign FlushE  = ~MemStallM & (ldStall | BranchTakenE);

    // Shadow pipeline: memory wait freezes E and M and drains a bubble into W.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            recE     <= BUBBLE;
            recM     <= BUBBLE;
            recW     <= BUBBLE;
            srcE     <= '0;
            srcUsedE <= '0;
        end else if (MemStallM) begin
            recW <= BUBBLE;
        end else begin
            recW <= recM;
            recM <= recE;
            if (FlushE) begin
                recE     <= BUBBLE;
                srcE     <= '0;
                srcUsedE <= '0;
            end else begin
                recE     <= recD;
                srcE     <= SrcRegD;
                srcUsedE <= SrcUsedD;
            end
        end
    end

    // Saturating stall/flush event counters; clear beats increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            CntStall <= '0;
            CntFlush <= '0;
        end else if (CntClr) begin
            CntStall <= '0;
            CntFlush <= '0;
        end else begin
            if (StallD && (CntStall != '1)) begin
                CntStall <= CntStall + CNT_W'(1);
            end
            if (FlushE && (CntFlush != '1)) begin
                CntFlush <= CntFlush + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_tracker.sv
// tb/tb_hazard_tracker.sv - scoreboard bench for hazard_tracker
module tb_hazard_tracker;
    import hazard_tracker_pkg::*;

    localparam int NSRC  = 2;
    localparam int NREG  = 16;
    localparam int CNT_W = 4;

    // Observed vector: {StallF,StallD,StallE,StallM,FlushD,FlushE,BubbleW, ForwardE[3:0], CntStall, CntFlush, vE,vM,vW}
    localparam logic [21:0] M_ALL = 22'h3FFFFF;
    localparam logic [21:0] M_HAZ = 22'h3F8000;
    localparam logic [21:0] M_FWD = 22'h007800;
    localparam logic [21:0] M_CS  = 22'h000780;
    localparam logic [21:0] M_CF  = 22'h000078;
    localparam logic [21:0] M_V   = 22'h000007;

    logic       clk = 1'b0;
    logic       reset;
    logic       ValidD;
    logic [7:0] SrcRegD;
    logic [1:0] SrcUsedD;
    logic [3:0] RdD;
    logic       RegWriteD, MemtoRegD, PCWriteD;
    logic       BranchTakenE, MemStallM, CntClr;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, BubbleW;
    logic [3:0] ForwardE;
    logic [3:0] CntStall, CntFlush;
    logic [21:0] obs;

    always #5 clk = ~clk;

    hazard_tracker #(.NSRC(NSRC), .NREG(NREG), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .ValidD(ValidD), .SrcRegD(SrcRegD), .SrcUsedD(SrcUsedD),
        .RdD(RdD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCWriteD(PCWriteD),
        .BranchTakenE(BranchTakenE), .MemStallM(MemStallM), .CntClr(CntClr),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .BubbleW(BubbleW), .ForwardE(ForwardE),
        .CntStall(CntStall), .CntFlush(CntFlush)
    );

    assign obs = {StallF, StallD, StallE, StallM, FlushD, FlushE, BubbleW, ForwardE,
                  CntStall, CntFlush, dut.recE.valid, dut.recM.valid, dut.recW.valid};

    typedef struct {
        string       name;
        logic [21:0] exp;
        logic [21:0] mask;
    } item_t;

    item_t sb[$];
    int applied     = 0;
    int miscompares = 0;

    function automatic logic [21:0] ex(input logic [6:0] haz, input logic [3:0] fwd,
                                       input logic [3:0] cs, input logic [3:0] cf,
                                       input logic [2:0] v);
        return {haz, fwd, cs, cf, v};
    endfunction

    task automatic setD(input logic v, input logic [3:0] s0, input logic [3:0] s1,
                        input logic [1:0] used, input logic [3:0] rd, input logic rw,
                        input logic m2r, input logic pcw);
        ValidD    = v;
        SrcRegD   = {s1, s0};
        SrcUsedD  = used;
        RdD       = rd;
        RegWriteD = rw;
        MemtoRegD = m2r;
        PCWriteD  = pcw;
    endtask

    task automatic idle();
        setD(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Inputs for this cycle are already applied; queue what the cycle must show.
    task automatic step(input string nm, input logic [21:0] e, input logic [21:0] m);
        item_t it;
        it.name = nm;
        it.exp  = e;
        it.mask = m;
        sb.push_back(it);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle's outputs are compared mid-cycle against the queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                item_t it;
                it = sb.pop_front();
                if (it.mask != 22'd0) begin
                    applied++;
                    if ((obs & it.mask) !== (it.exp & it.mask)) begin
                        miscompares++;
                        $display("FAIL %s: got %b want %b (mask %b)", it.name,
                                 obs & it.mask, it.exp & it.mask, it.mask);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; BranchTakenE = 1'b0; MemStallM = 1'b0; CntClr = 1'b0;
        idle();
        @(posedge clk);
        #1;

        // Reset state and live-input passthrough
        step("rst_idle", ex(7'b0000000, 4'h0, 4'd0, 4'd0, 3'b000), M_ALL);
        setD(1'b1, 4'd0, 4'd0, 2'b00, 4'd15, 1'b1, 1'b0, 1'b1);
        step("rst_pcw_masked", ex(7'b0000000, 4'h0, 4'd0, 4'd0, 3'b000), M_HAZ | M_V);
        idle(); MemStallM = 1'b1;
        step("rst_memstall", ex(7'b1111001, 4'h0, 4'd0, 4'd0, 3'b000), M_HAZ | M_CS | M_CF | M_V);
        MemStallM = 1'b0; BranchTakenE = 1'b1;
        step("rst_branch", ex(7'b0000110, 4'h0, 4'd0, 4'd0, 3'b000), M_HAZ | M_V);
        BranchTakenE = 1'b0; reset = 1'b1;

        // RAW forwarding: M then W
        setD(1'b1, 4'd1, 4'd2, 2'b11, 4'd3, 1'b1, 1'b0, 1'b0);
        step("raw_c1", ex(7'b0000000, 4'h0, 4'd0, 4'd0, 3'b000), M_ALL);
        setD(1'b1, 4'd3, 4'd4, 2'b11, 4'd5, 1'b1, 1'b0, 1'b0);
        step("raw_c2", ex(7'b0000000, 4'h0, 4'd0, 4'd0, 3'b100), M_ALL);
        setD(1'b1, 4'd6, 4'd3, 2'b11, 4'd7, 1'b1, 1'b0, 1'b0);
        step("raw_fwd_m", ex(7'b0000000, 4'b0010, 4'd0, 4'd0, 3'b110), M_ALL);
        idle();
        step("raw_fwd_w", ex(7'b0000000, 4'b0100, 4'd0, 4'd0, 3'b111), M_ALL);
        step("raw_drain1", ex(7'b0000000, 4'h0, 4'd0, 4'd0, 3'b011), M_ALL);
        step("raw_drain2", ex(7'b0000000, 4'h0, 4'd0, 4'd0, 3'b001), M_V);
        step("raw_drain3", ex(7'b0000000, 4'h0, 4'd0, 4'd0, 3'b000), M_V);

        // Load-use interlock
        setD(1'b1, 4'd1, 4'd0, 2'b01, 4'd2, 1'b1, 1'b1, 1'b0);
        step("lu_load", ex(7'b0000000, 4'h0, 4'd0, 4'd0, 3'b000), M_ALL);
        setD(1'b1, 4'd2, 4'd5, 2'b11, 4'd6, 1'b1, 1'b0, 1'b0);
        step("lu_stall", ex(7'b1100010, 4'h0, 4'd0, 4'd0, 3'b100), M_ALL);
        step("lu_release", ex(7'b0000000, 4'h0, 4'd1, 4'd1, 3'b010), M_ALL);
        idle();
        step("lu_fwd_w", ex(7'b0000000, 4'b0001, 4'd1, 4'd1, 3'b101), M_ALL);
        step("lu_drain1", ex(7'b0000000, 4'h0, 4'd1, 4'd1, 3'b010), M_V);
        step("lu_drain2", ex(7'b0000000, 4'h0, 4'd1, 4'd1, 3'b001), M_V);

        // PC write: D, E, M, W
        setD(1'b1, 4'd0, 4'd0, 2'b00, 4'd15, 1'b1, 1'b0, 1'b1);
        step("pc_d", ex(7'b1000100, 4'h0, 4'd1, 4'd1, 3'b000), M_ALL);
        idle();
        step("pc_e", ex(7'b1000100, 4'h0, 4'd1, 4'd1, 3'b100), M_ALL);
        step("pc_m", ex(7'b1000100, 4'h0, 4'd1, 4'd1, 3'b010), M_ALL);
        step("pc_w", ex(7'b0000100, 4'h0, 4'd1, 4'd1, 3'b001), M_ALL);
        step("pc_done", ex(7'b0000000, 4'h0, 4'd1, 4'd1, 3'b000), M_ALL);

        // PC register excluded from interlock and forwarding
        setD(1'b1, 4'd0, 4'd0, 2'b01, 4'd15, 1'b1, 1'b1, 1'b0);
        step("pcx_load", ex(7'b0000000, 4'h0, 4'd1, 4'd1, 3'b000), M_HAZ | M_FWD | M_V);
        setD(1'b1, 4'd15, 4'd0, 2'b01, 4'd4, 1'b1, 1'b0, 1'b0);
        step("pcx_nostall", ex(7'b0000000, 4'h0, 4'd1, 4'd1, 3'b100), M_HAZ | M_FWD | M_V);
        idle();
        step("pcx_nofwd", ex(7'b0000000, 4'h0, 4'd1, 4'd1, 3'b110), M_HAZ | M_FWD | M_V);
        step("pcx_drain1", ex(7'b0000000, 4'h0, 4'd1, 4'd1, 3'b011), M_V);
        step("pcx_drain2", ex(7'b0000000, 4'h0, 4'd1, 4'd1, 3'b001), M_V);

        // Memory wait with a pending taken branch
        setD(1'b1, 4'd0, 4'd0, 2'b00, 4'd3, 1'b1, 1'b0, 1'b0);
        step("mw_a", ex(7'b0000000, 4'h0, 4'd1, 4'd1, 3'b000), M_ALL);
        setD(1'b1, 4'd3, 4'd0, 2'b01, 4'd8, 1'b1, 1'b0, 1'b0);
        step("mw_b", ex(7'b0000000, 4'h0, 4'd1, 4'd1, 3'b100), M_ALL);
        idle(); MemStallM = 1'b1; BranchTakenE = 1'b1;
        step("mw_wait1", ex(7'b1111001, 4'b0010, 4'd1, 4'd1, 3'b110), M_ALL);
        step("mw_wait2", ex(7'b1111001, 4'b0010, 4'd2, 4'd1, 3'b110), M_ALL);
        step("mw_wait3", ex(7'b1111001, 4'b0010, 4'd3, 4'd1, 3'b110), M_ALL);
        MemStallM = 1'b0;
        step("mw_flush", ex(7'b0000110, 4'b0010, 4'd4, 4'd1, 3'b110), M_ALL);
        BranchTakenE = 1'b0;
        step("mw_after", ex(7'b0000000, 4'h0, 4'd4, 4'd2, 3'b011), M_ALL);

        // Counter saturation and clear priority
        MemStallM = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step($sformatf("sat_%0d", i),
                 ex(7'b1111001, 4'h0, (4 + i > 15) ? 4'd15 : 4'(4 + i), 4'd0, 3'b000),
                 M_HAZ | M_CS);
        end
        CntClr = 1'b1;
        step("clr_edge", ex(7'b1111001, 4'h0, 4'd15, 4'd2, 3'b000), M_CS | M_CF);
        CntClr = 1'b0; MemStallM = 1'b0;
        step("clr_zero", ex(7'b0000000, 4'h0, 4'd0, 4'd0, 3'b000), M_CS | M_CF);

        // Reset asserted in the middle of a load-use stall
        setD(1'b1, 4'd1, 4'd0, 2'b01, 4'd2, 1'b1, 1'b1, 1'b0);
        step("rlu_load", ex(7'b0000000, 4'h0, 4'd0, 4'd0, 3'b000), M_HAZ);
        setD(1'b1, 4'd2, 4'd5, 2'b11, 4'd6, 1'b1, 1'b0, 1'b0);
        step("rlu_stall", ex(7'b1100010, 4'h0, 4'd0, 4'd0, 3'b000), M_HAZ);
        reset = 1'b0;
        step("rlu_in_reset", ex(7'b0000000, 4'h0, 4'd0, 4'd0, 3'b000), M_ALL);
        reset = 1'b1;
        step("rlu_released", ex(7'b0000000, 4'h0, 4'd0, 4'd0, 3'b000), M_ALL);

        idle();
        @(negedge clk);
        #1;
        applied++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
